// File: rtl/fpm_ctrl_pkg.sv
// Shared state encoding and default sizing for the FP-multiplier test-loop controller.
package fpm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_t;

  localparam int DEF_N_OPS   = 32;
  localparam int DEF_LAT     = 4;
  localparam int DEF_TIMEOUT = 8;

endpackage

// File: rtl/fpm_lat_tracker.sv
// Valid-bit shift register mirroring the read + multiplier pipeline; the tail marks a result ready to write back.
module fpm_lat_tracker #(
  parameter int LAT = 4,
  parameter int OW  = $clog2(LAT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  output logic          tail,
  output logic [OW-1:0] occupancy
);

  logic [LAT-1:0] sr;

  // NOTE: non-blocking assignments let every stage sample the previous stage's old value in the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr[0] <= valid_in;
      for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
    end
  end

  assign tail = sr[LAT-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < LAT; i++) occupancy = occupancy + OW'(sr[i]);
  end

endmodule

// File: rtl/fpm_op_sequencer.sv
// Issues N_OPS operand reads, tracks them through the multiplier pipeline and writes results back,
// then waits (bounded) for the memory stack to confirm completion.
module fpm_op_sequencer
  import fpm_ctrl_pkg::*;
#(
  parameter int N_OPS   = DEF_N_OPS,
  parameter int LAT     = DEF_LAT,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = $clog2(N_OPS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          pause,
  input  logic          mem_done,
  output logic          start,
  output logic          we,
  output logic          we_ov,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] issued,
  output logic [CW-1:0] retired
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int OW = $clog2(LAT + 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [OW-1:0] occupancy;

  fpm_lat_tracker #(.LAT(LAT), .OW(OW)) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (start),
    .tail      (we),
    .occupancy (occupancy)
  );

  assign we_ov = we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      start   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      issued  <= '0;
      retired <= '0;
      tmo_cnt <= '0;
    end else begin
      if (we) retired <= retired + CW'(1);
      case (state)
        IDLE: begin
          if (go) begin
            state   <= ISSUE;
            start   <= !pause;
            busy    <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            issued  <= '0;
            retired <= '0;
          end
        end
        ISSUE: begin
          if (start) issued <= issued + CW'(1);
          if (start && issued == CW'(N_OPS - 1)) begin
            state <= DRAIN;
            start <= 1'b0;
          end else begin
            start <= !pause;
          end
        end
        DRAIN: begin
          // The last retirement can only occur here because LAT >= 1.
          if (we && retired == CW'(N_OPS - 1)) begin
            state   <= FINISH;
            tmo_cnt <= '0;
          end
        end
        FINISH: begin
          if (mem_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every issued pair is either still in the pipeline or already written back.
  always_ff @(posedge clk) begin
    if (!reset) assert (int'(retired) + int'(occupancy) == int'(issued));
  end

endmodule

// File: tb/tb_fpm_op_sequencer.sv
// Directed bench: per-cycle output traces compared as bit vectors against hand-derived cycle patterns.
module tb_fpm_op_sequencer;

  localparam int WIN = 48;

  logic       clk, reset, go, pause, mem_done;
  logic       start, we, we_ov, busy, done, err;
  logic [5:0] issued, retired;

  logic       go2, md2, start2, we2, we_ov2, busy2, done2, err2;
  logic [0:0] issued2, retired2;

  int n_cmp, n_err;

  logic [63:0] obs_start, obs_we, obs_ov, obs_busy, obs_done, obs_err;
  int          obs_issued [WIN];
  int          obs_retired[WIN];
  int          overlap;
  logic        pre_done;
  logic [17:0] rst_snap;

  fpm_op_sequencer dut (
    .clk(clk), .reset(reset), .go(go), .pause(pause), .mem_done(mem_done),
    .start(start), .we(we), .we_ov(we_ov), .busy(busy), .done(done), .err(err),
    .issued(issued), .retired(retired)
  );

  fpm_op_sequencer #(.N_OPS(1), .LAT(1), .TIMEOUT(8)) dut2 (
    .clk(clk), .reset(reset), .go(go2), .pause(1'b0), .mem_done(md2),
    .start(start2), .we(we2), .we_ov(we_ov2), .busy(busy2), .done(done2), .err(err2),
    .issued(issued2), .retired(retired2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle 0 = cycle in which go is presented; pf/pl = pause window, md = mem_done cycle,
  // gc = extra go cycle, rc = cycle in which reset is asserted (0 disables each).
  task automatic run(input int pf, input int pl, input int md, input int gc, input int rc);
    obs_start = '0; obs_we = '0; obs_ov = '0; obs_busy = '0; obs_done = '0; obs_err = '0;
    overlap = 0;
    @(negedge clk);
    pre_done = done;
    go = 1'b1;
    for (int c = 1; c < WIN; c++) begin
      @(negedge clk);
      obs_start[c]   = start;
      obs_we[c]      = we;
      obs_ov[c]      = we_ov;
      obs_busy[c]    = busy;
      obs_done[c]    = done;
      obs_err[c]     = err;
      obs_issued[c]  = int'(issued);
      obs_retired[c] = int'(retired);
      if (done && busy) overlap++;
      go       = (c == gc);
      pause    = (c >= pf && c < pf + pl);
      mem_done = (c == md);
      if (c == rc) begin
        reset = 1'b1;
        #1;
        rst_snap = {start, we, we_ov, busy, done, err, issued, retired};
      end
      if (c == rc + 1) reset = 1'b0;
    end
    go = 1'b0; pause = 1'b0; mem_done = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; go = 1'b0; pause = 1'b0; mem_done = 1'b0;
    go2 = 1'b0; md2 = 1'b0;
    #1;
    check("rst_outputs", 64'({start, we, we_ov, busy, done, err}), 64'h0);
    check("rst_counters", 64'({issued, retired}), 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic run, with an ignored go during ISSUE.
    run(0, 0, 37, 10, 0);
    check("basic_start", obs_start, 64'h0000_0001_FFFF_FFFE);
    check("basic_we",    obs_we,    64'h0000_001F_FFFF_FFE0);
    check("basic_we_ov", obs_ov,    64'h0000_001F_FFFF_FFE0);
    check("basic_busy",  obs_busy,  64'h0000_003F_FFFF_FFFE);
    check("basic_done",  obs_done,  64'h0000_FFC0_0000_0000);
    check("basic_err",   obs_err,   64'h0);
    check("busy_go_ignored_issued", 64'(obs_issued[11]), 64'd10);
    check("mid_issued_c20",  64'(obs_issued[20]),  64'd19);
    check("mid_retired_c20", 64'(obs_retired[20]), 64'd15);
    check("retired_c36", 64'(obs_retired[36]), 64'd31);
    check("basic_final_issued",  64'(obs_issued[WIN-1]),  64'd32);
    check("basic_final_retired", 64'(obs_retired[WIN-1]), 64'd32);
    check("basic_overlap", 64'(overlap), 64'd0);

    // Paused run, started while done is held from the previous run.
    run(10, 3, 40, 0, 0);
    check("pause_pre_done", 64'(pre_done), 64'd1);
    check("pause_start", obs_start, 64'h0000_000F_FFFF_C7FE);
    check("pause_we",    obs_we,    64'h0000_00FF_FFFC_7FE0);
    check("pause_busy",  obs_busy,  64'h0000_01FF_FFFF_FFFE);
    check("pause_done",  obs_done,  64'h0000_FE00_0000_0000);
    check("pause_issued_c1",  64'(obs_issued[1]),  64'd0);
    check("pause_issued_c14", 64'(obs_issued[14]), 64'd10);
    check("pause_final_retired", 64'(obs_retired[WIN-1]), 64'd32);
    check("pause_overlap", 64'(overlap), 64'd0);

    // mem_done never arrives.
    run(0, 0, 0, 0, 0);
    check("tmo_busy", obs_busy, 64'h0000_1FFF_FFFF_FFFE);
    check("tmo_done", obs_done, 64'h0000_E000_0000_0000);
    check("tmo_err",  obs_err,  64'h0000_E000_0000_0000);
    check("tmo_overlap", 64'(overlap), 64'd0);

    // Reset in cycle 20 abandons the in-flight ops.
    run(0, 0, 0, 0, 20);
    check("abort_snapshot", 64'(rst_snap), 64'h0);
    check("abort_start", obs_start, 64'h0000_0000_001F_FFFE);
    check("abort_we",    obs_we,    64'h0000_0000_001F_FFE0);
    check("abort_busy",  obs_busy,  64'h0000_0000_001F_FFFE);
    check("abort_done",  obs_done,  64'h0);

    run(0, 0, 37, 0, 0);
    check("rerun_start", obs_start, 64'h0000_0001_FFFF_FFFE);
    check("rerun_we",    obs_we,    64'h0000_001F_FFFF_FFE0);
    check("rerun_done",  obs_done,  64'h0000_FFC0_0000_0000);
    check("rerun_err",   obs_err,   64'h0);
    check("rerun_final_retired", 64'(obs_retired[WIN-1]), 64'd32);

    // Minimal configuration: one op, one-cycle latency.
    obs_start = '0; obs_we = '0; obs_busy = '0; obs_done = '0;
    @(negedge clk);
    go2 = 1'b1;
    for (int c = 1; c < 7; c++) begin
      @(negedge clk);
      obs_start[c] = start2;
      obs_we[c]    = we2;
      obs_busy[c]  = busy2;
      obs_done[c]  = done2;
      obs_issued[c]  = int'(issued2);
      obs_retired[c] = int'(retired2);
      go2 = 1'b0;
      md2 = (c == 3);
    end
    md2 = 1'b0;
    check("min_start", obs_start, 64'h02);
    check("min_we",    obs_we,    64'h04);
    check("min_busy",  obs_busy,  64'h0E);
    check("min_done",  obs_done,  64'h70);
    check("min_err",   64'(err2), 64'd0);
    check("min_cnt_c2", 64'({obs_issued[2][0], obs_retired[2][0]}), 64'b10);
    check("min_cnt_c3", 64'({obs_issued[3][0], obs_retired[3][0]}), 64'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
